tspc_frame_deser: RTL and testbench



---
 rtl/tspc_deser_pkg.sv | 19 +
 rtl/tspc_sync_detect.sv | 35 +++
 rtl/tspc_frame_deser.sv | 155 +++++++++++++++
 tb/tb_tspc_frame_deser.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tspc_deser_pkg.sv
// Shared definitions for the TSPC frame deserializer.
// Contents:
//   state_e          HUNT/LOCK encoding (ST_HUNT=0, ST_LOCK=1)
//   DEF_*            default parameter values
//   cnt_w()          bit-counter width, able to count to WORD_W (parity adds one bit)
package tspc_deser_pkg;

  typedef enum logic {ST_HUNT = 1'b0, ST_LOCK = 1'b1} state_e;

  localparam int         DEF_WORD_W       = 8;
  localparam int         DEF_SYNC_W       = 8;
  localparam logic [7:0] DEF_SYNC_PATTERN = 8'hA5;
  localparam int         DEF_FRAME_WORDS  = 2;

  function automatic int cnt_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/tspc_sync_detect.sv
// Sliding-window sync pattern detector.
// Ports:
//   clk_i, rst_i  clock / synchronous active-high reset
//   shift_i       take bit_i into the window this cycle
//   clr_i         clear the window (held while the deserializer is locked)
//   bit_i         serial input bit, newest bit enters the LSB
//   match_o       combinational: {window, bit_i} equals SYNC_PATTERN on a shift cycle
module tspc_sync_detect #(
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic shift_i,
  input  logic clr_i,
  input  logic bit_i,
  output logic match_o
);

  // Only the previous SYNC_W-1 bits need storing; the oldest bit of a full
  // SYNC_W window would be shifted out on the very cycle it is compared.
  logic [SYNC_W-2:0] win_q;
  logic [SYNC_W-1:0] cand;

  assign cand    = {win_q, bit_i};
  assign match_o = shift_i && (cand == SYNC_PATTERN);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)
      win_q <= '0;
    else if (shift_i)
      win_q <= cand[SYNC_W-2:0];
  end

endmodule

// File: rtl/tspc_frame_deser.sv
// Frame deserializer for the TSPC flip-flop Q stream.
// Hunts for SYNC_PATTERN, then assembles FRAME_WORDS words of WORD_W bits
// (MSB first) and presents them through a single-entry valid/ready buffer.
// Optional build macro TSPC_DESER_PARITY_EN: every word carries a trailing
// even-parity bit; bad words pulse parity_err and are not loaded.
// Ports:
//   clk_in, rst_in      clock / synchronous active-high reset
//   q_in, q_en          serial bit and its per-cycle enable
//   word_out/valid/ready  output word handshake
//   sync_lock           high while inside a frame
//   overflow            sticky, a good word was dropped on a full buffer
//   parity_err          one-cycle pulse on a parity failure
module tspc_frame_deser
  import tspc_deser_pkg::*;
#(
  parameter int                WORD_W       = DEF_WORD_W,
  parameter int                SYNC_W       = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEF_SYNC_PATTERN),
  parameter int                FRAME_WORDS  = DEF_FRAME_WORDS
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              q_in,
  input  logic              q_en,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              sync_lock,
  output logic              overflow,
  output logic              parity_err
);

`ifdef TSPC_DESER_PARITY_EN
  localparam int WORD_BITS = WORD_W + 1;
`else
  localparam int WORD_BITS = WORD_W;
`endif
  localparam int CNT_W  = cnt_w(WORD_W);
  localparam int WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WORD_BITS-2:0] asm_q;
  logic [WORD_BITS-1:0] full_word;
  logic [WORD_W-1:0]   data_w, word_q;
  logic                valid_q, ovf_q;
  logic                sync_hit, word_done, par_ok, load_ok, can_load;

  tspc_sync_detect #(
    .SYNC_W      (SYNC_W),
    .SYNC_PATTERN(SYNC_PATTERN)
  ) u_sync (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .shift_i(q_en && (state_q == ST_HUNT)),
    .clr_i  (state_q == ST_LOCK),
    .bit_i  (q_in),
    .match_o(sync_hit)
  );

  // Word as it stands including this cycle's bit; valid only when word_done.
  assign full_word = {asm_q, q_in};
  assign data_w    = full_word[WORD_BITS-1 -: WORD_W];
  assign word_done = (state_q == ST_LOCK) && q_en && (bit_cnt_q == CNT_W'(WORD_BITS - 1));

`ifdef TSPC_DESER_PARITY_EN
  assign par_ok = ~^full_word;
`else
  assign par_ok = 1'b1;
`endif

  assign load_ok  = word_done && par_ok;
  assign can_load = !valid_q || word_ready;  // free, or draining this cycle

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      ST_HUNT: begin
        if (sync_hit) begin
          state_d    = ST_LOCK;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      ST_LOCK: begin
        if (word_done) begin
          bit_cnt_d = '0;
          if (word_cnt_q == WCNT_W'(FRAME_WORDS - 1)) begin
            state_d    = ST_HUNT;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end else if (q_en) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_HUNT;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      // Stale bits from an earlier partial word are fully shifted out
      // before the next completion, so no clear is needed on lock entry.
      if ((state_q == ST_LOCK) && q_en)
        asm_q <= full_word[WORD_BITS-2:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (load_ok && can_load) begin
        word_q  <= data_w;
        valid_q <= 1'b1;
      end else if (valid_q && word_ready) begin
        valid_q <= 1'b0;
      end
      if (load_ok && !can_load)
        ovf_q <= 1'b1;
    end
  end

`ifdef TSPC_DESER_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) perr_q <= 1'b0;
    else        perr_q <= word_done && !par_ok;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign sync_lock  = (state_q == ST_LOCK);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_tspc_frame_deser.sv
// Bench for tspc_frame_deser: per-cycle comparison against a bit-stream
// reference model, a table of directed streams, hand sequences for reset,
// enable gaps and backpressure release, and a randomized run.
module tb_tspc_frame_deser;

`ifdef TSPC_DESER_PARITY_EN
  localparam int WB = 9;
`else
  localparam int WB = 8;
`endif

  logic       clk = 1'b0, rst = 1'b1, q = 1'b0, en = 1'b0, rdy = 1'b1;
  logic [7:0] word_out;
  logic       word_valid, sync_lock, overflow, parity_err;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  tspc_frame_deser dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .q_in      (q),
    .q_en      (en),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(rdy),
    .sync_lock (sync_lock),
    .overflow  (overflow),
    .parity_err(parity_err)
  );

  // Reference model: the spec's rules on a bit history and a bit list.
  bit         m_lock, m_valid, m_ovf, m_perr;
  logic [7:0] m_hist, m_word;
  logic [15:0] m_acc;
  int         m_nbits, m_words;

  logic [7:0] got[$];
  int         perr_cnt, stepn, first_v;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit done, ok;
    logic [15:0] wbits;
    logic [7:0]  data;
    done  = 0;
    ok    = 1;
    wbits = '0;
    if (rst) begin
      m_lock = 0; m_valid = 0; m_ovf = 0; m_perr = 0;
      m_hist = '0; m_word = '0; m_acc = '0; m_nbits = 0; m_words = 0;
      return;
    end
    m_perr = 0;
    if (en) begin
      if (!m_lock) begin
        m_hist = {m_hist[6:0], q};
        if (m_hist == 8'hA5) begin
          m_lock = 1; m_nbits = 0; m_words = 0;
        end
      end else begin
        m_acc = {m_acc[14:0], q};
        m_nbits++;
        if (m_nbits == WB) begin
          done = 1; wbits = m_acc; m_nbits = 0; m_words++;
          if (m_words == 2) begin
            m_lock = 0; m_hist = '0;
          end
        end
      end
    end
    data = (WB == 9) ? wbits[8:1] : wbits[7:0];
    if (done && WB == 9) ok = (^wbits[8:0]) == 1'b0;
    if (done && !ok) m_perr = 1;
    if (done && ok && (!m_valid || rdy)) begin
      m_word = data; m_valid = 1;
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (done && ok) m_ovf = 1;
    end
  endtask

  task automatic step(input logic qi, input logic ei, input logic ri, input logic rsti);
    q = qi; en = ei; rdy = ri; rst = rsti;
    if (word_valid === 1'b1 && rdy && !rst) got.push_back(word_out);
    @(posedge clk);
    model_edge();
    #1;
    stepn++;
    if (word_valid === 1'b1 && first_v < 0) first_v = stepn;
    if (parity_err === 1'b1) perr_cnt++;
    check("cycle", {20'd0, word_valid, word_out, sync_lock, overflow, parity_err},
          {20'd0, m_valid, m_word, m_lock, m_ovf, m_perr});
  endtask

  task automatic do_reset();
    repeat (3) step(1'($urandom % 2), 1'b1, 1'b1, 1'b1);
    check("reset_outs", {27'd0, word_valid, sync_lock, overflow, parity_err, |word_out}, 32'd0);
    got.delete();
    perr_cnt = 0;
  endtask

  // Bits are taken MSB-first from the left end of s.
  task automatic send(input logic [63:0] s, input int n, input logic r);
    for (int i = 0; i < n; i++) step(s[63-i], 1'b1, r, 1'b0);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, 1'b0);
  endtask

  typedef struct {
    logic [63:0] s;
    int          n;
    logic        r;
    int          ndel;
    logic [7:0]  d0, d1;
    logic        fv;
    logic [7:0]  fw;
    logic        fo;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] rbyte;
    int         rbit;
    stepn = 0; first_v = -1; perr_cnt = 0;
    do_reset();

`ifndef TSPC_DESER_PARITY_EN
    tbl[0] = '{64'hA53C5A00_00000000, 24, 1'b1, 2, 8'h3C, 8'h5A, 1'b0, 8'h5A, 1'b0};
    tbl[1] = '{64'hA53C5A00_00000000, 24, 1'b0, 0, 8'h00, 8'h00, 1'b1, 8'h3C, 1'b1};
    tbl[2] = '{64'hA4000000_00000000,  8, 1'b1, 0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{64'hA4A53C5A_00000000, 32, 1'b1, 2, 8'h3C, 8'h5A, 1'b0, 8'h5A, 1'b0};
    // 0x52 followed by the leading 1 of A5 already reads A5, so lock comes
    // one bit early and the words are 4A, 78.
    tbl[4] = '{64'h52A53C5A_00000000, 32, 1'b1, 2, 8'h4A, 8'h78, 1'b0, 8'h78, 1'b0};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      send(tbl[i].s, tbl[i].n, tbl[i].r);
      idle(2, tbl[i].r);
      check($sformatf("v%0d_ndel", i), got.size(), tbl[i].ndel);
      if (tbl[i].ndel > 0)
        check($sformatf("v%0d_d0", i), got.size() > 0 ? {24'd0, got[0]} : 32'hx, {24'd0, tbl[i].d0});
      if (tbl[i].ndel > 1)
        check($sformatf("v%0d_d1", i), got.size() > 1 ? {24'd0, got[1]} : 32'hx, {24'd0, tbl[i].d1});
      check($sformatf("v%0d_final", i), {21'd0, word_valid, word_out, overflow, sync_lock},
            {21'd0, tbl[i].fv, tbl[i].fw, tbl[i].fo, 1'b0});
    end

    // Backpressure release: old word accepted, valid drops, overflow sticks.
    do_reset();
    send(64'hA53C5A00_00000000, 24, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_release", {30'd0, word_valid, overflow}, 32'd1);
    check("bp_got", got.size() == 1 ? {24'd0, got[0]} : 32'hx, 32'h3C);

    // Mid-frame reset after 4 data bits, then re-lock.
    do_reset();
    send(64'hA5300000_00000000, 12, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("mid_rst_lock", {31'd0, sync_lock}, 32'd0);
    send(64'hC0000000_00000000, 4, 1'b1);
    check("mid_rst_novalid", {31'd0, word_valid}, 32'd0);
    send(64'hA53C5A00_00000000, 24, 1'b1);
    idle(2, 1'b1);
    check("mid_rst_got", got.size() == 2 ? {16'd0, got[0], got[1]} : 32'hx, 32'h3C5A);

    // Enable gap of 5 cycles mid-word: first word appears 5 steps later.
    do_reset();
    stepn = 0; first_v = -1;
    send(64'hA5300000_00000000, 12, 1'b1);
    for (int i = 0; i < 5; i++) step(1'($urandom % 2), 1'b0, 1'b1, 1'b0);
    send(64'hC5A00000_00000000, 12, 1'b1);
    idle(2, 1'b1);
    check("gap_latency", first_v, 21);
    check("gap_got", got.size() == 2 ? {16'd0, got[0], got[1]} : 32'hx, 32'h3C5A);
`else
    // A5, then 3C with good parity 0, then 3D with bad parity 0.
    do_reset();
    send({8'hA5, 8'h3C, 1'b0, 8'h3D, 1'b0, 38'd0}, 26, 1'b1);
    idle(2, 1'b1);
    check("par_got", got.size() == 1 ? {24'd0, got[0]} : 32'hx, 32'h3C);
    check("par_err_cnt", perr_cnt, 1);
    check("par_lock", {30'd0, sync_lock, overflow}, 32'd0);
`endif

    // Randomized run; a quarter of the bytes are the sync pattern.
    do_reset();
    rbyte = 8'hA5;
    rbit  = 7;
    for (int c = 0; c < 2500; c++) begin
      step(rbyte[rbit], 1'(($urandom % 5) != 0), 1'(($urandom % 3) != 0),
           1'(($urandom % 400) == 0));
      if (en) begin
        if (rbit == 0) begin
          rbyte = (($urandom % 4) == 0) ? 8'hA5 : 8'($urandom);
          rbit  = 7;
        end else begin
          rbit--;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
